adl5201_spi_readback: RTL



---
 rtl/adl5201_spi_readback.sv | 125 ++++++++++++
 1 files changed

// File: rtl/adl5201_spi_readback.sv
// 3-wire SPI read engine for the ADL5201 gain port: sends {1,addr}, releases SDIO,
// captures one data byte and flags it against the expected gain word.
module adl5201_spi_readback #(
  parameter int HALF_DIV = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       RD_REQ,
  input  logic [6:0] RD_ADDR,
  input  logic [7:0] RD_EXPECT,
  output logic       RD_BUSY,
  output logic       RD_DONE,
  output logic [7:0] RD_DATA,
  output logic       RD_MISMATCH,
  output logic       SPI_CS,
  output logic       SPI_SCLK,
  output logic       SPI_SDO,
  output logic       SPI_SDO_OE,
  input  logic       SPI_SDI
);

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, DATA, HOLD, GAP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        sclk_q;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  expect_q;
  logic        done_q;
  logic [7:0]  rd_data_q;
  logic        mismatch_q;
  logic        half_end;
  logic        period_end;

  assign half_end   = (div_cnt == HALF_LAST);
  assign period_end = half_end && sclk_q;

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // bit_cnt runs 0..15 across CMD and DATA so one counter covers the whole frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (RD_REQ)                          state_nxt = SETUP;
      SETUP: if (half_end)                        state_nxt = CMD;
      CMD:   if (period_end && bit_cnt == 5'd7)   state_nxt = DATA;
      DATA:  if (period_end && bit_cnt == 5'd15)  state_nxt = HOLD;
      HOLD:  if (half_end)                        state_nxt = GAP;
      GAP:   if (div_cnt == GAP_LAST)             state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SPI_CS      = (state == IDLE) || (state == GAP);
    SPI_SDO_OE  = (state == SETUP) || (state == CMD);
    SPI_SDO     = SPI_SDO_OE & tx_sr[7];
    SPI_SCLK    = sclk_q;
    RD_BUSY     = (state != IDLE);
    RD_DONE     = done_q;
    RD_DATA     = rd_data_q;
    RD_MISMATCH = mismatch_q;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      div_cnt    <= 8'd0;
      bit_cnt    <= 5'd0;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= 8'd0;
      mismatch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= 8'd0;
          bit_cnt <= 5'd0;
          sclk_q  <= 1'b0;
        end
        SETUP: div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
        CMD, DATA: begin
          if (half_end) begin
            div_cnt <= 8'd0;
            sclk_q  <= ~sclk_q;
            if (sclk_q) bit_cnt <= bit_cnt + 5'd1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
          if (half_end) begin
            done_q     <= 1'b1;
            rd_data_q  <= rx_sr;
            mismatch_q <= (rx_sr != expect_q);
          end
        end
        GAP:     div_cnt <= div_cnt + 8'd1;
        default: div_cnt <= 8'd0;
      endcase
    end
  end

  // Shift registers: tx advances as SCLK falls, rx samples on the last high cycle
  always_ff @(posedge CLK) begin
    if (state == IDLE && RD_REQ) begin
      tx_sr    <= {1'b1, RD_ADDR};
      expect_q <= RD_EXPECT;
    end
    if (state == CMD && period_end)  tx_sr <= {tx_sr[6:0], 1'b0};
    if (state == DATA && period_end) rx_sr <= {rx_sr[6:0], SPI_SDI};
  end

endmodule
